// File: rtl/seg_scan_capture_if.sv
// Tap-side bundle for seg_scan_capture: the multiplexed display bus in, recovered frame out.
// master drives AN/SEGMENT and observes results; slave is the capture block.
interface seg_scan_capture_if;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  LEs;
    logic        valid;
    logic        frame_done;
    logic        stale;
    logic        err;

    modport master (
        output AN, SEGMENT,
        input  hexs, points, LEs, valid, frame_done, stale, err
    );

    modport slave (
        input  AN, SEGMENT,
        output hexs, points, LEs, valid, frame_done, stale, err
    );
endinterface

// File: rtl/seg_scan_capture.sv
// Recovers hex value, decimal points and blank flags from a multiplexed active-low 7-seg bus.
// Digit captured after STABLE_CYC stable clocks; frame published the cycle after all four digits are seen.
module seg_scan_capture #(
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT_W  = 20
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_capture_if.slave  bus
);
    localparam logic [7:0] STB_MAX = 8'(STABLE_CYC);
    localparam logic [7:0] STB_HIT = 8'(STABLE_CYC - 2);

    logic [11:0]          sync1_q, sync2_q, prev_q;
    logic [7:0]           stb_q, stb_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [15:0]          shex_q, shex_d, hexs_q, hexs_d;
    logic [3:0]           spts_q, spts_d, sle_q, sle_d, seen_q, seen_d;
    logic [3:0]           pts_q, pts_d, les_q, les_d;
    logic                 valid_q, valid_d, done_q, done_d;
    logic                 stale_q, stale_d, err_q, err_d;

    logic [3:0] s_an, sel_oh;
    logic [7:0] s_seg;
    logic       same, strobe, frame_cmp, tmo_full;
    logic       dec_ok, dec_blank;
    logic [3:0] dec_nib;

    always_comb begin
        s_an  = sync2_q[11:8];
        s_seg = sync2_q[7:0];
        sel_oh = ~s_an;
        same  = (sync2_q == prev_q);

        dec_ok    = 1'b1;
        dec_blank = 1'b0;
        dec_nib   = 4'h0;
        case (s_seg[6:0])
            7'h40: dec_nib = 4'h0;
            7'h79: dec_nib = 4'h1;
            7'h24: dec_nib = 4'h2;
            7'h30: dec_nib = 4'h3;
            7'h19: dec_nib = 4'h4;
            7'h12: dec_nib = 4'h5;
            7'h02: dec_nib = 4'h6;
            7'h78: dec_nib = 4'h7;
            7'h00: dec_nib = 4'h8;
            7'h10: dec_nib = 4'h9;
            7'h08: dec_nib = 4'hA;
            7'h03: dec_nib = 4'hB;
            7'h46: dec_nib = 4'hC;
            7'h21: dec_nib = 4'hD;
            7'h06: dec_nib = 4'hE;
            7'h0E: dec_nib = 4'hF;
            7'h7F: dec_blank = 1'b1;
            default: dec_ok = 1'b0;
        endcase

        stb_d = stb_q;
        if (!same)
            stb_d = 8'd0;
        else if (stb_q < STB_MAX)
            stb_d = stb_q + 8'd1;

        // One strobe per dwell: the counter passes STB_HIT only once before saturating.
        strobe    = same && (stb_q == STB_HIT) && $onehot(sel_oh);
        frame_cmp = (seen_q == 4'hF);
        tmo_full  = &tmo_q;

        seen_d = frame_cmp ? 4'h0 : seen_q;
        shex_d = shex_q;
        spts_d = spts_q;
        sle_d  = sle_q;
        err_d  = err_q;
        if (strobe) begin
            if (dec_ok) begin
                seen_d = seen_d | sel_oh;
                for (int i = 0; i < 4; i++) begin
                    if (sel_oh[i]) begin
                        shex_d[i*4 +: 4] = dec_nib;
                        spts_d[i]        = ~s_seg[7];
                        sle_d[i]         = dec_blank;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end

        if (strobe)
            tmo_d = '0;
        else if (tmo_full)
            tmo_d = tmo_q;
        else
            tmo_d = tmo_q + TIMEOUT_W'(1);

        hexs_d  = hexs_q;
        pts_d   = pts_q;
        les_d   = les_q;
        valid_d = valid_q;
        stale_d = stale_q;
        done_d  = frame_cmp;
        // Frame completion outranks a coincident timeout.
        if (frame_cmp) begin
            hexs_d  = shex_q;
            pts_d   = spts_q;
            les_d   = sle_q;
            valid_d = 1'b1;
            stale_d = 1'b0;
        end else if (tmo_full) begin
            valid_d = 1'b0;
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            stb_q   <= '0;
            tmo_q   <= '0;
            shex_q  <= '0;
            spts_q  <= '0;
            sle_q   <= '0;
            seen_q  <= '0;
            hexs_q  <= '0;
            pts_q   <= '0;
            les_q   <= 4'hF;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            stale_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= {bus.AN, bus.SEGMENT};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            stb_q   <= stb_d;
            tmo_q   <= tmo_d;
            shex_q  <= shex_d;
            spts_q  <= spts_d;
            sle_q   <= sle_d;
            seen_q  <= seen_d;
            hexs_q  <= hexs_d;
            pts_q   <= pts_d;
            les_q   <= les_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            stale_q <= stale_d;
            err_q   <= err_d;
        end
    end

    assign bus.hexs       = hexs_q;
    assign bus.points     = pts_q;
    assign bus.LEs        = les_q;
    assign bus.valid      = valid_q;
    assign bus.frame_done = done_q;
    assign bus.stale      = stale_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture with a short timeout (TIMEOUT_W=8).
module tb_seg_scan_capture;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   fd_cnt = 0;
    int   snap;

    seg_scan_capture_if bus();

    seg_scan_capture #(.STABLE_CYC(4), .TIMEOUT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.frame_done === 1'b1) fd_cnt++;

    task automatic put(input int idx, input logic [7:0] seg, input int n);
        bus.AN = ~(4'b0001 << idx);
        bus.SEGMENT = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic gap(input int n);
        bus.AN = 4'hF;
        bus.SEGMENT = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        bus.AN = 4'hF;
        bus.SEGMENT = 8'hFF;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        total++; if (bus.hexs !== 16'h0) begin bad++; $display("FAIL reset_hexs got=%h want=0000", bus.hexs); end
        total++; if (bus.points !== 4'h0) begin bad++; $display("FAIL reset_points got=%h want=0", bus.points); end
        total++; if (bus.LEs !== 4'hF) begin bad++; $display("FAIL reset_LEs got=%h want=f", bus.LEs); end
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", bus.frame_done); end
        total++; if (bus.stale !== 1'b0) begin bad++; $display("FAIL reset_stale got=%b want=0", bus.stale); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err); end
    endtask

    task automatic test_timeout;
        gap(200);
        total++; if (bus.stale !== 1'b0) begin bad++; $display("FAIL idle_stale_early got=%b want=0", bus.stale); end
        gap(60);
        total++; if (bus.stale !== 1'b1) begin bad++; $display("FAIL idle_stale got=%b want=1", bus.stale); end
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", bus.valid); end
        total++; if (bus.hexs !== 16'h0) begin bad++; $display("FAIL idle_hexs got=%h want=0000", bus.hexs); end
        total++; if (bus.LEs !== 4'hF) begin bad++; $display("FAIL idle_LEs got=%h want=f", bus.LEs); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL idle_err got=%b want=0", bus.err); end
        total++; if (fd_cnt !== 0) begin bad++; $display("FAIL idle_frames got=%0d want=0", fd_cnt); end
    endtask

    task automatic test_frame;
        snap = fd_cnt;
        put(3, 8'hF9, 8); put(2, 8'hA4, 8); put(1, 8'hB0, 8); put(0, 8'h99, 8);
        gap(6);
        total++; if (fd_cnt - snap !== 1) begin bad++; $display("FAIL frame_pulses got=%0d want=1", fd_cnt - snap); end
        total++; if (bus.hexs !== 16'h1234) begin bad++; $display("FAIL frame_hexs got=%h want=1234", bus.hexs); end
        total++; if (bus.points !== 4'h0) begin bad++; $display("FAIL frame_points got=%h want=0", bus.points); end
        total++; if (bus.LEs !== 4'h0) begin bad++; $display("FAIL frame_LEs got=%h want=0", bus.LEs); end
        total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL frame_valid got=%b want=1", bus.valid); end
        total++; if (bus.stale !== 1'b0) begin bad++; $display("FAIL frame_stale got=%b want=0", bus.stale); end
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL frame_done_width got=%b want=0", bus.frame_done); end
    endtask

    task automatic test_dp_blank;
        snap = fd_cnt;
        put(3, 8'hC6, 8); put(2, 8'hA1, 8); put(1, 8'h06, 8); put(0, 8'hFF, 8);
        gap(6);
        total++; if (fd_cnt - snap !== 1) begin bad++; $display("FAIL dp_pulses got=%0d want=1", fd_cnt - snap); end
        total++; if (bus.hexs !== 16'hCDE0) begin bad++; $display("FAIL dp_hexs got=%h want=cde0", bus.hexs); end
        total++; if (bus.points !== 4'b0010) begin bad++; $display("FAIL dp_points got=%b want=0010", bus.points); end
        total++; if (bus.LEs !== 4'b0001) begin bad++; $display("FAIL dp_LEs got=%b want=0001", bus.LEs); end
    endtask

    task automatic test_glitch;
        snap = fd_cnt;
        put(3, 8'h90, 8); put(2, 8'h82, 3); put(1, 8'hF8, 8); put(0, 8'h82, 8);
        gap(6);
        total++; if (fd_cnt - snap !== 0) begin bad++; $display("FAIL glitch_early got=%0d want=0", fd_cnt - snap); end
        put(2, 8'h80, 8);
        gap(6);
        total++; if (fd_cnt - snap !== 1) begin bad++; $display("FAIL glitch_pulses got=%0d want=1", fd_cnt - snap); end
        total++; if (bus.hexs !== 16'h9876) begin bad++; $display("FAIL glitch_hexs got=%h want=9876", bus.hexs); end
    endtask

    task automatic test_illegal;
        snap = fd_cnt;
        put(3, 8'hC0, 8); put(2, 8'hF9, 8); put(1, 8'hA4, 8); put(0, 8'hD5, 8);
        gap(6);
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b want=1", bus.err); end
        total++; if (fd_cnt - snap !== 0) begin bad++; $display("FAIL illegal_pulses got=%0d want=0", fd_cnt - snap); end
        total++; if (bus.hexs !== 16'h9876) begin bad++; $display("FAIL illegal_hold got=%h want=9876", bus.hexs); end
        put(0, 8'hB0, 8);
        gap(6);
        total++; if (fd_cnt - snap !== 1) begin bad++; $display("FAIL legal_pulses got=%0d want=1", fd_cnt - snap); end
        total++; if (bus.hexs !== 16'h0123) begin bad++; $display("FAIL legal_hexs got=%h want=0123", bus.hexs); end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", bus.err); end
    endtask

    task automatic test_mid_reset;
        put(3, 8'h99, 8); put(2, 8'h92, 8);
        gap(2);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        total++; if (bus.hexs !== 16'h0) begin bad++; $display("FAIL mrst_hexs got=%h want=0000", bus.hexs); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL mrst_err got=%b want=0", bus.err); end
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b want=0", bus.valid); end
        snap = fd_cnt;
        put(3, 8'h80, 8); put(2, 8'h90, 8); put(1, 8'h88, 8); put(0, 8'h83, 8);
        gap(6);
        total++; if (fd_cnt - snap !== 1) begin bad++; $display("FAIL mrst_pulses got=%0d want=1", fd_cnt - snap); end
        total++; if (bus.hexs !== 16'h89AB) begin bad++; $display("FAIL mrst_frame got=%h want=89ab", bus.hexs); end
        total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL mrst_frame_valid got=%b want=1", bus.valid); end
    endtask

    initial begin
        bus.AN = 4'hF;
        bus.SEGMENT = 8'hFF;
        @(negedge clk);
        test_reset;
        test_timeout;
        test_frame;
        test_dp_blank;
        test_glitch;
        test_illegal;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Reads the multiplexed 7-segment bus (AN, SEGMENT) that the display driver produces and reconstructs the values behind it.
- Recovered per frame: 16-bit hex value, decimal points and blanked-digit flags.
- Uses: on-board loopback self-check of the display path, and the bench-side monitor for display-driver verification.
- Sits beside the display driver: its inputs tap the same AN/SEGMENT nets; its outputs feed a compare/LED block.

Parameters:
- STABLE_CYC, 4: consecutive clocks a sampled {AN,SEGMENT} must stay unchanged before the digit is captured; legal range 2..255.
- TIMEOUT_W, 20: width of the refresh-timeout counter; timeout fires after 2^TIMEOUT_W-1 clocks without a capture.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- AN  in  4  digit enables, active-low; AN[i]=0 selects digit i (digit 3 = hexs[15:12]).
- SEGMENT  in  8  active-low segments; [0]=a … [6]=g, [7]=dp.
- hexs  out  16  recovered nibbles of the last complete frame.
- points  out  4  recovered decimal points; 1 = dp lit.
- LEs  out  4  1 = digit blank (all segments off).
- valid  out  1  a complete, non-stale frame is held on hexs/points/LEs.
- frame_done  out  1  one-cycle pulse when outputs update.
- stale  out  1  no capture within the timeout window.
- err  out  1  sticky: an illegal segment pattern was seen.

Behaviour:
- Reset (rst=0 at a clk edge):
  - hexs=0, points=0, LEs=4'hF, valid=0, frame_done=0, stale=0, err=0.
  - Sync registers, stability counter, seen-mask, shadow registers and timeout counter are cleared.
  - Reset asserted mid-frame discards all partial captures.
- Input path:
  - {AN,SEGMENT} pass through a 2-flop synchronizer; s = the stage-2 value, s_prev = s delayed one clock.
- Stability counter:
  - Cleared when s≠s_prev.
  - Incremented, saturating at STABLE_CYC, when s==s_prev.
- Capture strobe:
  - Fires exactly once per dwell, in the cycle the counter reaches STABLE_CYC-1 …
  - … and only if s.AN has exactly one zero bit.
  - AN=4'hF (blanking gap) or multiple zeros: no capture, no error.
- Decode of s.SEGMENT[6:0] (gfedcba, active-low):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F.
  - 7F → blank: shadow LE=1, nibble=0.
  - Any other pattern: err←1; the digit is neither updated nor marked seen.
- Decimal point: shadow point = ~SEGMENT[7], captured with the digit, including for blank digits.
- Seen-mask:
  - A legal capture sets seen[i].
  - Recapture of an already-seen digit overwrites its shadow value; the mask is unchanged.
- Frame completion:
  - In the cycle after seen becomes 4'hF: shadow values copy to the outputs, frame_done=1 for one clock, valid=1, stale=0, seen clears.
  - A capture in that same cycle goes into the cleared mask for the next frame.
- Latency: a new digit held on the bus reaches the outputs 2 (sync) + STABLE_CYC + 1 clocks after the bus settles, provided it completes the frame.
- Timeout:
  - The counter clears on every capture strobe and otherwise increments.
  - At all-ones: stale=1, valid=0, counter holds. hexs/points/LEs retain their last values.
  - Cleared by the next frame_done.
- err clears only on reset.
- Simultaneous timeout saturation and frame completion: frame completion wins (stale=0, valid=1).

Test Plan:
- Reset then idle with AN=F, SEGMENT=FF for 2^TIMEOUT_W clocks (TIMEOUT_W=8 in bench) → outputs stay at reset values; stale=1 after 255 clocks; err=0.
- Scan digits 3..0 with patterns 79,24,30,19 (dp off, SEGMENT[7]=1), 8 clocks each → one frame_done pulse; hexs=16'h1234, points=0, LEs=0, valid=1.
- Scan 46,21,06,0E with dp lit on digit 1 and digit 0 pattern 7F → hexs=16'hCDE0, points=4'b0010, LEs=4'b0001.
- Glitch: hold digit 2 for STABLE_CYC-1 clocks only, then a stable full frame → no capture from the short dwell; frame matches the stable values.
- Illegal pattern 55 on digit 0 → err=1 (sticky), no frame_done until a legal digit-0 pattern arrives.
- Reset pulse after 2 digits captured, then a full scan of 8,9,A,b → hexs=16'h89AB, exactly one frame_done after reset.
